// File: rtl/cmp_sweep_ctrl.sv
// cmp_sweep_ctrl: sweeps all 16 {b,a} vectors through a 2-bit comparator and checks each result against b>a.
module cmp_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [1:0]  cmp_b,
  output logic [1:0]  cmp_a,
  input  logic        cmp_gt,
  output logic        busy,
  output logic        done,
  output logic [15:0] gt_map,
  output logic [15:0] err_map,
  output logic [4:0]  err_cnt,
  output logic        pass
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       golden;
  logic       mism;
  assign golden = idx[3:2] > idx[1:0];
  assign mism   = cmp_gt != golden;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      cmp_b   <= '0;
      cmp_a   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt_map  <= '0;
      err_map <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start && !abort) begin
          state   <= ST_SETTLE;
          idx     <= '0;
          cnt     <= '0;
          cmp_b   <= '0;
          cmp_a   <= '0;
          busy    <= 1'b1;
          gt_map  <= '0;
          err_map <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
        end
        ST_SETTLE: if (abort) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else if (cnt == LAST) begin
          state <= ST_SAMPLE;
        end else begin
          cnt <= cnt + 4'd1;
        end
        ST_SAMPLE: if (abort) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          gt_map[idx] <= cmp_gt;
          if (mism) begin
            err_map[idx] <= 1'b1;
            err_cnt      <= err_cnt + 5'(err_cnt != 5'd16);
          end
          if (idx == 4'd15) begin
            // pass is formed here so the final sample's verdict is included
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 5'd0) && !mism;
          end else begin
            state          <= ST_SETTLE;
            idx            <= idx + 4'd1;
            cnt            <= '0;
            {cmp_b, cmp_a} <= idx + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// tb_cmp_sweep_ctrl: randomized comparator fault maps, scoreboard of expected sweep results checked on done.
module tb_cmp_sweep_ctrl;
  localparam int S   = 2;
  localparam int LAT = 16 * (S + 1);
  typedef struct {
    int          done_cyc;
    logic [15:0] gt;
    logic [15:0] err;
    logic [4:0]  cnt;
    logic        pass;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        abort = 0;
  logic        cmp_gt;
  logic [1:0]  cmp_b, cmp_a;
  logic        busy, done, pass;
  logic [15:0] gt_map, err_map;
  logic [4:0]  err_cnt;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mode = 0;
  logic [15:0] flip = '0;
  exp_t        q[$];
  logic        pp_pend = 0;
  logic        pp_exp = 0;
  wire  [3:0]  v = {cmp_b, cmp_a};

  cmp_sweep_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cmp_b(cmp_b), .cmp_a(cmp_a), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .gt_map(gt_map), .err_map(err_map),
    .err_cnt(err_cnt), .pass(pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // comparator under test: 0 good, 1 stuck-0, 2 stuck-1, 3 good with random per-vector faults
  assign cmp_gt = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ((cmp_b > cmp_a) ^ (mode == 3 && flip[v]));

  function automatic logic golden(int n);
    return (n / 4) > (n % 4);
  endfunction

  function automatic logic model_gt(int n);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return golden(n) ^ (mode == 3 && flip[n]);
  endfunction

  function automatic exp_t build(int acc);
    exp_t e;
    e.gt = '0;
    e.err = '0;
    for (int n = 0; n < 16; n++) begin
      e.gt[n]  = model_gt(n);
      e.err[n] = e.gt[n] ^ golden(n);
    end
    e.cnt = 5'($countones(e.err));
    e.pass = e.cnt == 0;
    e.done_cyc = acc + LAT;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pp_pend) begin
        check("pass", 32'(pass), 32'(pp_exp));
        pp_pend = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("gt_map", 32'(gt_map), 32'(e.gt));
          check("err_map", 32'(err_map), 32'(e.err));
          check("err_cnt", 32'(err_cnt), 32'(e.cnt));
          check("busy_at_done", 32'(busy), 32'd0);
          pp_exp = e.pass;
          pp_pend = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected %0d pending", q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  task automatic run(int m, logic [15:0] f);
    mode = m;
    flip = f;
    start = 1;
    q.push_back(build(cyc + 1));
    tick();
    start = 0;
    drain();
  endtask

  initial begin
    exp_t e;
    int   found;
    tick();
    tick();
    check("reset_maps", {gt_map, err_map}, 32'd0);
    check("reset_ctl", 32'({busy, done, cmp_b, cmp_a, err_cnt, pass}), 32'd0);
    rst_n = 1;
    run(0, '0);
    check("good_gt_map", 32'(gt_map), 32'h7310);
    check("good_pass", 32'(pass), 32'd1);
    run(1, '0);
    check("stuck0_err_map", 32'(err_map), 32'h7310);
    run(2, '0);
    check("stuck1_err_cnt", 32'(err_cnt), 32'd10);
    for (int k = 0; k < 4; k++) run(3, 16'($urandom));
    run(3, 16'hFFFF);

    mode = 3;
    flip = 16'($urandom) | 16'h0011;
    start = 1;
    tick();
    start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (busy && v == 4'd5) found = 1;
      else tick();
    end
    check("abort_reach_vec5", 32'(found), 32'd1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", 32'(busy), 32'd0);
    e = build(0);
    check("abort_gt_map", 32'(gt_map), 32'(e.gt & 16'h001F));
    check("abort_err_map", 32'(err_map), 32'(e.err & 16'h001F));
    check("abort_err_cnt", 32'(err_cnt), 32'($countones(e.err & 16'h001F)));
    check("abort_pass", 32'(pass), 32'd0);
    repeat (LAT + 5) tick();
    check("abort_hold_gt", 32'(gt_map), 32'(e.gt & 16'h001F));
    run(0, '0);

    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    check("abort_wins_busy", 32'(busy), 32'd0);
    repeat (LAT + 5) tick();
    check("idle_hold_gt", 32'(gt_map), 32'h7310);

    mode = 2;
    start = 1;
    q.push_back(build(cyc + 1));
    for (int i = 0; i < LAT + 20 && q.size() > 0; i++) tick();
    check("held_start_one_done", 32'(q.size()), 32'd0);
    check("held_start_idle_gap", 32'(busy), 32'd0);
    mode = 0;
    q.push_back(build(cyc + 1));
    tick();
    start = 0;
    check("held_start_restart", 32'(busy), 32'd1);
    drain();

    mode = 0;
    start = 1;
    q.push_back(build(cyc + 1));
    tick();
    start = 0;
    repeat (20) tick();
    #3;
    rst_n = 0;
    #1;
    q.delete();
    check("midrst_maps", {gt_map, err_map}, 32'd0);
    check("midrst_ctl", 32'({busy, done, cmp_b, cmp_a, err_cnt, pass}), 32'd0);
    tick();
    tick();
    rst_n = 1;
    run(3, 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmp_sweep_ctrl.md
CMP_SWEEP_CTRL -- requirements
Module: cmp_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles each vector is held on the comparator before sampling; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a full 16-vector sweep; sampled on clk.
REQ-005 Port: abort  input  1  terminate a sweep in progress.
REQ-006 Port: cmp_b  output  2  B operand to the comparator (b1 b0, drives x3 x2).
REQ-007 Port: cmp_a  output  2  A operand to the comparator (a1 a0, drives x1 x0).
REQ-008 Port: cmp_gt  input  1  comparator result B>A.
REQ-009 Port: busy  output  1  high while a sweep is in progress.
REQ-010 Port: done  output  1  one-cycle pulse on sweep completion.
REQ-011 Port: gt_map  output  16  captured cmp_gt per vector; bit n is vector n = {b,a}.
REQ-012 Port: err_map  output  16  bit n set when the captured value differs from golden (b>a unsigned).
REQ-013 Port: err_cnt  output  5  count of mismatching vectors, 0..16.
REQ-014 Port: pass  output  1  high when the last completed sweep had err_cnt==0.

Function
REQ-015 States SHALL be IDLE, SETTLE, SAMPLE and DONE; busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-016 IDLE: when start=1 and abort=0, the block SHALL next enter SETTLE with idx=0 and clear gt_map, err_map, err_cnt and pass.
REQ-017 cmp_b and cmp_a SHALL be registered and SHALL equal idx[3:2] and idx[1:0] throughout SETTLE and SAMPLE; they SHALL hold their last value in IDLE and DONE.
REQ-018 SETTLE SHALL last exactly SETTLE cycles per vector, counted by an internal 4-bit counter, then go to SAMPLE.
REQ-019 SAMPLE (1 cycle): the block SHALL write cmp_gt into gt_map[idx], compare it to golden (idx[3:2] > idx[1:0]), set err_map[idx] and increment err_cnt on mismatch.
REQ-020 SAMPLE: if idx==15 the block SHALL go to DONE; otherwise it SHALL increment idx and return to SETTLE.
REQ-021 DONE: done SHALL be 1 for this single cycle; pass SHALL be loaded with (err_cnt==0) including the final sample; the next state SHALL be IDLE.
REQ-022 With start accepted in cycle t, done SHALL be high in cycle t+1+16*(SETTLE+1); for SETTLE=2 this is t+49.
REQ-023 start SHALL be ignored in SETTLE, SAMPLE and DONE; it SHALL not queue.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge with no done pulse and no further map update; partial maps SHALL be held and pass SHALL stay 0.
REQ-025 abort and start both high in IDLE: abort SHALL win and no sweep SHALL start.
REQ-026 err_cnt SHALL never exceed 16 and SHALL not wrap.
REQ-027 gt_map, err_map, err_cnt and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, idx=0, cmp_b=0, cmp_a=0, busy=0, done=0, gt_map=0, err_map=0, err_cnt=0 and pass=0, including mid-sweep.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-030 Correct comparator model, SETTLE=2, start pulse -> done at t+49, gt_map=0x7310, err_map=0x0000, err_cnt=0, pass=1.
REQ-031 cmp_gt stuck at 0 -> gt_map=0x0000, err_map=0x7310, err_cnt=6, pass=0.
REQ-032 cmp_gt stuck at 1 -> gt_map=0xFFFF, err_map=0x8CEF, err_cnt=10, pass=0.
REQ-033 abort during vector 5 -> busy=0 next cycle, no done, gt_map bits 5..15=0; a new start then yields a full, correct sweep.
REQ-034 start held high for the whole sweep -> exactly one sweep and one done pulse; a second sweep begins only after return to IDLE.
REQ-035 rst_n pulsed low mid-sweep -> all outputs 0 asynchronously, and no done pulse.
